// File: rtl/l2_arbiter.sv
// ----------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single L2 burst port between the ICache (port 0) and the DCache
// (port 1). One-cycle request pulses from each L1 are captured in a one-deep
// pending latch per port. Requests are issued to L2 one at a time with
// round-robin priority. The owning port keeps L2 until its whole burst has
// completed.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   pN_rreq / pN_wreq   : one-cycle read / write request pulse from L1 N
//   pN_addr             : burst base address, valid in the request cycle
//   pN_burst_size       : burst length in words (0 is treated as 1)
//   pN_wdata            : write beat from L1 N
//   pN_rdata            : read beat to L1 N (mirror of l2_rdata)
//   pN_busy             : stall to L1 N; low while beats flow or when idle
//   l2_rreq / l2_wreq   : registered one-cycle request pulse to L2
//   l2_addr             : registered burst address, held until next issue
//   l2_burst_size       : registered burst length (0 mapped to 1)
//   l2_wdata            : write beat muxed from the owning port
//   l2_rdata, l2_busy   : read beat and busy from L2
//   owner               : port holding L2, meaningful while active=1
//   active              : high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
module l2_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_rreq,
  input  logic        p0_wreq,
  input  logic [31:0] p0_addr,
  input  logic [4:0]  p0_burst_size,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_busy,
  input  logic        p1_rreq,
  input  logic        p1_wreq,
  input  logic [31:0] p1_addr,
  input  logic [4:0]  p1_burst_size,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_busy,
  output logic        l2_rreq,
  output logic        l2_wreq,
  output logic [31:0] l2_addr,
  output logic [4:0]  l2_burst_size,
  output logic [31:0] l2_wdata,
  input  logic [31:0] l2_rdata,
  input  logic        l2_busy,
  output logic        owner,
  output logic        active
);

  localparam int N_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [4:0]  beat_cnt;

  logic        pend_valid [N_PORTS];
  logic        pend_write [N_PORTS];
  logic [31:0] pend_addr  [N_PORTS];
  logic [4:0]  pend_size  [N_PORTS];

  logic        req        [N_PORTS];
  logic        req_write  [N_PORTS];
  logic [31:0] req_addr   [N_PORTS];
  logic [4:0]  req_size   [N_PORTS];

  logic        cand       [N_PORTS];
  logic        take       [N_PORTS];
  logic        any_cand;
  logic        grant;
  logic        grant_write;
  logic [31:0] grant_addr;
  logic [4:0]  grant_size;

  // A zero-length burst still moves one word.
  function automatic logic [4:0] norm_size(input logic [4:0] size);
    if (size == 5'd0) begin
      return 5'd1;
    end else begin
      return size;
    end
  endfunction

  // Busy seen by one L1: owner follows the burst phase, others reflect their latch.
  function automatic logic port_busy(input logic is_owner, input state_t st,
                                     input logic l2b, input logic pend);
    logic b;
    if (is_owner) begin
      case (st)
        ST_ISSUE: b = 1'b1;
        ST_WAIT:  b = l2b;
        ST_DATA:  b = 1'b0;
        default:  b = pend;
      endcase
    end else begin
      b = pend;
    end
    return b;
  endfunction

  // Gather the raw per-port request fields into arrays.
  always_comb begin
    req[0]       = p0_rreq | p0_wreq;
    req_write[0] = p0_wreq;
    req_addr[0]  = p0_addr;
    req_size[0]  = p0_burst_size;
    req[1]       = p1_rreq | p1_wreq;
    req_write[1] = p1_wreq;
    req_addr[1]  = p1_addr;
    req_size[1]  = p1_burst_size;
  end

  // Round-robin choice among pending latches and this cycle's raw pulses.
  always_comb begin
    cand[0]  = pend_valid[0] | req[0];
    cand[1]  = pend_valid[1] | req[1];
    any_cand = cand[0] | cand[1];
    if (cand[0] && cand[1]) begin
      grant = ~last_grant;
    end else if (cand[0]) begin
      grant = 1'b0;
    end else begin
      grant = 1'b1;
    end
    take[0] = (state == ST_IDLE) && any_cand && !grant;
    take[1] = (state == ST_IDLE) && any_cand && grant;
    // A latched request always predates a raw pulse on the same port.
    if (pend_valid[grant]) begin
      grant_write = pend_write[grant];
      grant_addr  = pend_addr[grant];
      grant_size  = pend_size[grant];
    end else begin
      grant_write = req_write[grant];
      grant_addr  = req_addr[grant];
      grant_size  = req_size[grant];
    end
  end

  // Per-port pending latch: cleared on grant, loaded by an ungranted pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        pend_valid[i] <= 1'b0;
        pend_write[i] <= 1'b0;
        pend_addr[i]  <= 32'd0;
        pend_size[i]  <= 5'd0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (take[i]) begin
          pend_valid[i] <= 1'b0;
        end else if (req[i] && !pend_valid[i]) begin
          pend_valid[i] <= 1'b1;
          pend_write[i] <= req_write[i];
          pend_addr[i]  <= req_addr[i];
          pend_size[i]  <= req_size[i];
        end else begin
          // A pulse on an already-full latch is a protocol violation; drop it.
          pend_valid[i] <= pend_valid[i];
        end
      end
    end
  end

  // Ownership state machine with registered L2 request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      active        <= 1'b0;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      l2_rreq       <= 1'b0;
      l2_wreq       <= 1'b0;
      l2_addr       <= 32'd0;
      l2_burst_size <= 5'd0;
      beat_cnt      <= 5'd0;
    end else begin
      l2_rreq <= 1'b0;
      l2_wreq <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_cand) begin
            state         <= ST_ISSUE;
            active        <= 1'b1;
            l2_rreq       <= ~grant_write;
            l2_wreq       <= grant_write;
            l2_addr       <= grant_addr;
            l2_burst_size <= norm_size(grant_size);
            owner         <= grant;
            last_grant    <= grant;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The cycle busy drops is read beat 0; DATA then runs for B cycles.
          if (!l2_busy) begin
            state    <= ST_DATA;
            beat_cnt <= l2_burst_size;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DATA: begin
          if (beat_cnt == 5'd1) begin
            state    <= ST_IDLE;
            active   <= 1'b0;
            beat_cnt <= 5'd0;
          end else begin
            beat_cnt <= beat_cnt - 5'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  // Busy to each L1 and write-data steering toward L2.
  always_comb begin
    p0_busy = port_busy(active && (owner == 1'b0), state, l2_busy, pend_valid[0]);
    p1_busy = port_busy(active && (owner == 1'b1), state, l2_busy, pend_valid[1]);
    if (((state == ST_WAIT) || (state == ST_DATA)) && owner) begin
      l2_wdata = p1_wdata;
    end else begin
      l2_wdata = p0_wdata;
    end
  end

  assign p0_rdata = l2_rdata;
  assign p1_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// ----------------------------------------------------------------------------
// tb_l2_arbiter
//
// Directed bench for l2_arbiter. A transaction-level model (pending slots,
// issue/fall timestamps) predicts every output each cycle and is compared on
// the falling edge; directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_l2_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_rreq = 1'b0, p0_wreq = 1'b0;
  logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0;
  logic [4:0]  p0_burst_size = 5'd0;
  logic [31:0] p0_rdata;
  logic        p0_busy;
  logic        p1_rreq = 1'b0, p1_wreq = 1'b0;
  logic [31:0] p1_addr = 32'd0, p1_wdata = 32'd0;
  logic [4:0]  p1_burst_size = 5'd0;
  logic [31:0] p1_rdata;
  logic        p1_busy;
  logic        l2_rreq, l2_wreq;
  logic [31:0] l2_addr, l2_wdata;
  logic [4:0]  l2_burst_size;
  logic [31:0] l2_rdata = 32'd0;
  logic        l2_busy = 1'b0;
  logic        owner, active;

  l2_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_rreq(p0_rreq), .p0_wreq(p0_wreq), .p0_addr(p0_addr),
    .p0_burst_size(p0_burst_size), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_busy(p0_busy),
    .p1_rreq(p1_rreq), .p1_wreq(p1_wreq), .p1_addr(p1_addr),
    .p1_burst_size(p1_burst_size), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_busy(p1_busy),
    .l2_rreq(l2_rreq), .l2_wreq(l2_wreq), .l2_addr(l2_addr),
    .l2_burst_size(l2_burst_size), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_busy(l2_busy),
    .owner(owner), .active(active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- L2 responder: busy for 'lat' cycles from each request ----
  int lat = 2;
  int busy_left = 0;
  logic [31:0] rd_cnt = 32'hA000_0000;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy_left = 0;
    end else if (l2_rreq || l2_wreq) begin
      busy_left = lat;
    end
    l2_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    rd_cnt   = rd_cnt + 32'd1;
    l2_rdata = rd_cnt;
  end

  // ---------------- transaction-level reference model ------------------------
  bit          mv [2] = '{1'b0, 1'b0};
  bit          mw [2];
  logic [31:0] ma [2];
  logic [4:0]  ms [2];
  bit          m_txn = 1'b0;
  int          m_issue = 0;
  int          m_fall = -1;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  bit          m_write = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [4:0]  m_B = 5'd0;
  int          cyc = 0;

  bit          pr [2];
  bit          pw [2];
  logic [31:0] pa [2];
  logic [4:0]  ps [2];
  logic [31:0] pwd [2];
  logic        e_busy [2];
  logic        dut_busy [2];
  int          g;

  always @(negedge clk) begin
    pr[0] = p0_rreq | p0_wreq;  pw[0] = p0_wreq;  pa[0] = p0_addr;  ps[0] = p0_burst_size;  pwd[0] = p0_wdata;
    pr[1] = p1_rreq | p1_wreq;  pw[1] = p1_wreq;  pa[1] = p1_addr;  ps[1] = p1_burst_size;  pwd[1] = p1_wdata;
    dut_busy[0] = p0_busy;
    dut_busy[1] = p1_busy;
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        if (m_txn && (m_owner == n[0])) begin
          if (cyc == m_issue)   e_busy[n] = 1'b1;
          else if (m_fall < 0)  e_busy[n] = l2_busy;
          else                  e_busy[n] = 1'b0;
        end else begin
          e_busy[n] = mv[n];
        end
      end
      check("m_active", active, m_txn);
      check("m_l2_rreq", l2_rreq, m_txn && (cyc == m_issue) && !m_write);
      check("m_l2_wreq", l2_wreq, m_txn && (cyc == m_issue) && m_write);
      check("m_l2_addr", l2_addr, m_addr);
      check("m_l2_size", l2_burst_size, m_B);
      if (m_txn) check("m_owner", owner, m_owner);
      check("m_p0_busy", dut_busy[0], e_busy[0]);
      check("m_p1_busy", dut_busy[1], e_busy[1]);
      check("m_l2_wdata", l2_wdata, (m_txn && (cyc > m_issue)) ? pwd[m_owner] : pwd[0]);
      check("m_p0_rdata", p0_rdata, l2_rdata);
      check("m_p1_rdata", p1_rdata, l2_rdata);
    end
    // advance the model across the coming rising edge
    if (reset) begin
      mv[0] = 1'b0; mv[1] = 1'b0;
      m_txn = 1'b0; m_fall = -1; m_owner = 1'b0; m_last = 1'b1;
      m_write = 1'b0; m_addr = 32'd0; m_B = 5'd0;
    end else if (m_txn) begin
      if ((m_fall < 0) && (cyc > m_issue) && !l2_busy) m_fall = cyc;
      if ((m_fall >= 0) && (cyc == m_fall + int'(m_B))) m_txn = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (pr[i] && !mv[i]) begin
          mv[i] = 1'b1; mw[i] = pw[i]; ma[i] = pa[i]; ms[i] = ps[i];
        end
      end
    end else if (mv[0] || pr[0] || mv[1] || pr[1]) begin
      if ((mv[0] || pr[0]) && (mv[1] || pr[1])) g = m_last ? 0 : 1;
      else if (mv[0] || pr[0])                 g = 0;
      else                                     g = 1;
      if (mv[g]) begin
        m_write = mw[g]; m_addr = ma[g]; m_B = ms[g];
        mv[g] = 1'b0;
      end else begin
        m_write = pw[g]; m_addr = pa[g]; m_B = ps[g];
      end
      if (m_B == 5'd0) m_B = 5'd1;
      m_txn = 1'b1; m_issue = cyc + 1; m_fall = -1;
      m_owner = g[0]; m_last = g[0];
      if (pr[1-g] && !mv[1-g]) begin
        mv[1-g] = 1'b1; mw[1-g] = pw[1-g]; ma[1-g] = pa[1-g]; ms[1-g] = ps[1-g];
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_reqs();
    p0_rreq = 1'b0; p0_wreq = 1'b0;
    p1_rreq = 1'b0; p1_wreq = 1'b0;
  endtask

  task automatic drive_req(input int p, input bit wr, input logic [31:0] a, input logic [4:0] s);
    if (p == 0) begin
      p0_rreq = !wr; p0_wreq = wr; p0_addr = a; p0_burst_size = s;
    end else begin
      p1_rreq = !wr; p1_wreq = wr; p1_addr = a; p1_burst_size = s;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Step until l2_busy is low (beat 0); reports whether it happened in time.
  task automatic wait_fall(input string name);
    int n;
    n = 0;
    while (l2_busy && n < 40) begin
      tick();
      n++;
    end
    check(name, !l2_busy, 1'b1);
  endtask

  // Step until active drops; returns number of steps taken.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (active && n < 80) begin
      tick();
      n++;
    end
    check(name, active, 1'b0);
  endtask

  int cnt;
  bit grants [$];
  bit pulse0, pulse1;

  initial begin
    // ---- reset state ----
    tick();
    chk_en = 1'b1;
    do_reset();
    check("rst_active", active, 1'b0);
    check("rst_l2_rreq", l2_rreq, 1'b0);
    check("rst_l2_wreq", l2_wreq, 1'b0);
    check("rst_l2_addr", l2_addr, 32'd0);
    check("rst_owner", owner, 1'b0);
    check("rst_p0_busy", p0_busy, 1'b0);
    check("rst_p1_busy", p1_busy, 1'b0);

    // ---- single read on port 1 ----
    lat = 3;
    drive_req(1, 1'b0, 32'h0000_1000, 5'd8);
    tick();
    clear_reqs();
    check("rd_l2_rreq", l2_rreq, 1'b1);
    check("rd_l2_addr", l2_addr, 32'h0000_1000);
    check("rd_l2_size", l2_burst_size, 5'd8);
    check("rd_owner", owner, 1'b1);
    check("rd_p1_busy_issue", p1_busy, 1'b1);
    wait_fall("rd_busy_fall");
    check("rd_p1_busy_beat0", p1_busy, 1'b0);
    wait_idle("rd_idle", cnt);
    check("rd_active_len", cnt, 9);
    tick();

    // ---- simultaneous requests after reset ----
    do_reset();
    lat = 2;
    drive_req(0, 1'b0, 32'h0000_0100, 5'd4);
    drive_req(1, 1'b1, 32'h0000_0200, 5'd2);
    tick();
    clear_reqs();
    check("sim_owner0", owner, 1'b0);
    check("sim_l2_rreq", l2_rreq, 1'b1);
    check("sim_addr0", l2_addr, 32'h0000_0100);
    check("sim_p1_busy", p1_busy, 1'b1);
    wait_idle("sim_idle0", cnt);
    check("sim_gap_wreq", l2_wreq, 1'b0);
    tick();
    check("sim_l2_wreq", l2_wreq, 1'b1);
    check("sim_owner1", owner, 1'b1);
    check("sim_addr1", l2_addr, 32'h0000_0200);
    wait_idle("sim_idle1", cnt);
    tick();

    // ---- write data routing ----
    lat = 2;
    p0_wdata = 32'hDEAD_BEEF;
    p1_wdata = 32'h5000_0000;
    drive_req(1, 1'b1, 32'h0000_0300, 5'd8);
    tick();
    clear_reqs();
    check("wr_wdata_issue", l2_wdata, 32'hDEAD_BEEF);
    cnt = 0;
    while (active && cnt < 80) begin
      tick();
      p1_wdata = p1_wdata + 32'd1;
      cnt++;
    end
    check("wr_idle", active, 1'b0);
    check("wr_wdata_after", l2_wdata, 32'hDEAD_BEEF);
    tick();

    // ---- fairness with both ports requesting continuously ----
    do_reset();
    lat = 1;
    grants.delete();
    cnt = 0;
    while (grants.size() < 4 && cnt < 300) begin
      if (l2_rreq || l2_wreq) grants.push_back(owner);
      pulse0 = !p0_busy && !(active && owner == 1'b0);
      pulse1 = !p1_busy && !(active && owner == 1'b1);
      p0_rreq = pulse0; p0_addr = 32'h0000_0400; p0_burst_size = 5'd2;
      p1_wreq = pulse1; p1_addr = 32'h0000_0500; p1_burst_size = 5'd2;
      tick();
      cnt++;
    end
    clear_reqs();
    check("fair_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      check("fair_g0", grants[0], 1'b0);
      check("fair_g1", grants[1], 1'b1);
      check("fair_g2", grants[2], 1'b0);
      check("fair_g3", grants[3], 1'b1);
    end
    cnt = 0;
    while ((active || p0_busy || p1_busy) && cnt < 100) begin
      tick();
      cnt++;
    end
    check("fair_drain", active, 1'b0);
    tick();

    // ---- zero burst size ----
    lat = 2;
    drive_req(0, 1'b0, 32'h0000_0600, 5'd0);
    tick();
    clear_reqs();
    check("zero_size", l2_burst_size, 5'd1);
    wait_fall("zero_fall");
    wait_idle("zero_idle", cnt);
    check("zero_data_cycles", cnt, 2);
    tick();

    // ---- reset mid-burst with port 0 pending ----
    lat = 2;
    drive_req(1, 1'b0, 32'h0000_0700, 5'd8);
    tick();
    clear_reqs();
    wait_fall("mid_fall");
    tick();
    tick();
    drive_req(0, 1'b0, 32'h0000_0800, 5'd3);
    tick();
    clear_reqs();
    check("mid_p0_pending", p0_busy, 1'b1);
    check("mid_active", active, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_active", active, 1'b0);
    check("mid_rst_rreq", l2_rreq, 1'b0);
    check("mid_rst_wreq", l2_wreq, 1'b0);
    check("mid_rst_p0_busy", p0_busy, 1'b0);
    check("mid_rst_p1_busy", p1_busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_post_idle", active, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_checks);
    $fatal(1);
  end

endmodule
